// File: rtl/scfifo_s_wr_arb.sv
// scfifo_s_wr_arb: round-robin write arbiter merging NUM_REQ requesters into one shared FIFO as {id, payload} beats.
// Optional packet lock (grant held until req_last) is enabled by defining SCFIFO_S_WR_ARB_PKT_LOCK_EN.
module scfifo_s_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 20,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     sclr,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ID_W+WIDTH-1:0]    fifo_data,
    output logic                     fifo_wrreq,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic                     fifo_sclr,
    output logic                     overflow_err
);
    logic [ID_W-1:0]    ptr, gnt_id, rr_id;
    logic [NUM_REQ-1:0] rot;
    logic               found, arb_en, acc, ptr_upd;
    logic [WIDTH-1:0]   gnt_data;
    int                 off, sum;

    // rotate valids so bit 0 is the requester just after ptr, then take the lowest set bit
    always_comb begin
        rot = NUM_REQ'({req_valid, req_valid} >> (ptr + 1'b1));
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) off = k;
        sum   = int'(ptr) + 1 + off;
        rr_id = ID_W'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
    end

`ifdef SCFIFO_S_WR_ARB_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t          state, state_nxt;
    logic [ID_W-1:0] lock_id;
    logic            gnt_last;

    always_ff @(posedge clock or negedge aclr_n)
        if (!aclr_n) begin
            state   <= IDLE;
            lock_id <= '0;
        end else if (sclr) begin
            state   <= IDLE;
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (acc && state == IDLE) lock_id <= gnt_id;
        end

    always_comb begin
        state_nxt = state;
        if (acc) state_nxt = gnt_last ? IDLE : LOCKED;
    end

    assign gnt_id   = (state == LOCKED) ? lock_id : rr_id;
    assign found    = (state == LOCKED) ? req_valid[lock_id] : |req_valid;
    assign gnt_last = req_last[gnt_id];
    assign ptr_upd  = acc && gnt_last;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign gnt_id      = rr_id;
    assign found       = |req_valid;
    assign ptr_upd     = acc;
`endif

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_id == ID_W'(i)) gnt_data = req_data[i*WIDTH +: WIDTH];
    end

    // arb_en keeps req_ready low until the first edge after reset release
    assign acc       = arb_en && found && !fifo_almost_full && !sclr;
    assign req_ready = acc ? (NUM_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge clock or negedge aclr_n)
        if (!aclr_n) begin
            arb_en       <= 1'b0;
            ptr          <= ID_W'(NUM_REQ - 1);
            fifo_wrreq   <= 1'b0;
            fifo_data    <= '0;
            fifo_sclr    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            arb_en    <= 1'b1;
            fifo_sclr <= sclr;
            if (sclr) begin
                ptr          <= ID_W'(NUM_REQ - 1);
                fifo_wrreq   <= 1'b0;
                fifo_data    <= '0;
                overflow_err <= 1'b0;
            end else begin
                fifo_wrreq   <= acc;
                overflow_err <= overflow_err | (fifo_wrreq & fifo_full);
                if (acc) fifo_data <= {gnt_id, gnt_data};
                if (ptr_upd) ptr <= gnt_id;
            end
        end
endmodule

// File: tb/tb_scfifo_s_wr_arb.sv
// tb_scfifo_s_wr_arb: directed and random stimulus against a behavioural round-robin arbiter model.
// Exercises the packet-lock variant when SCFIFO_S_WR_ARB_PKT_LOCK_EN is defined.
module tb_scfifo_s_wr_arb;
    localparam int N = 4, W = 20, IW = 2;

    logic           clock = 0, aclr_n = 0, sclr = 0, fifo_full = 0, fifo_almost_full = 0;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
    logic [N*W-1:0] req_data = '0;
    logic [IW+W-1:0] fifo_data;
    logic           fifo_wrreq, fifo_sclr, overflow_err;

    int tests = 0, fails = 0, cyc = 0;
    int m_ptr = N - 1, m_lid = 0;
    bit m_lock = 0, m_en = 0, m_wr = 0, m_ovf = 0, m_fsclr = 0;
    logic [IW+W-1:0] m_data = '0;
    int got_id[$], got_cyc[$];
    logic [IW+W-1:0] got_data[$];

    scfifo_s_wr_arb dut (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .fifo_sclr(fifo_sclr), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_ready"}, req_ready, 0);
        chk({nm, "_wrreq"}, fifo_wrreq, 0);
        chk({nm, "_data"}, fifo_data, 0);
        chk({nm, "_sclr"}, fifo_sclr, 0);
        chk({nm, "_ovf"}, overflow_err, 0);
    endtask

    task automatic chk_ids(string nm, int n, int e[8]);
        chk({nm, "_count"}, got_id.size(), n);
        for (int i = 0; i < n; i++) chk(nm, i < got_id.size() ? got_id[i] : -1, e[i]);
    endtask

    task automatic clr_log();
        got_id.delete(); got_cyc.delete(); got_data.delete(); cyc = 0;
    endtask

    task automatic model_reset();
        m_ptr = N - 1; m_lock = 0; m_lid = 0; m_en = 0; m_wr = 0; m_ovf = 0; m_fsclr = 0; m_data = '0;
    endtask

    // first eligible requester searching upward from ptr+1, or -1
    function automatic int pick();
        int c;
        if (m_lock) return ((req_valid >> m_lid) & 1) != 0 ? m_lid : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (((req_valid >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] er;
        logic [W-1:0] pl;
        #4;
        g  = pick();
        er = (m_en && !fifo_almost_full && !sclr && g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", req_ready, er);
        chk("fifo_wrreq", fifo_wrreq, m_wr);
        chk("fifo_data", fifo_data, m_data);
        chk("overflow_err", overflow_err, m_ovf);
        chk("fifo_sclr", fifo_sclr, m_fsclr);
        if (fifo_wrreq) begin
            got_id.push_back(int'(fifo_data[IW+W-1:W]));
            got_cyc.push_back(cyc);
            got_data.push_back(fifo_data);
        end
        if (aclr_n) begin
            pl      = (g >= 0) ? W'(req_data >> (g * W)) : '0;
            m_ovf   = !sclr && (m_ovf || (m_wr && fifo_full));
            m_fsclr = sclr;
            m_en    = 1;
            if (sclr) begin
                m_ptr = N - 1; m_lock = 0; m_wr = 0; m_data = '0;
            end else begin
                m_wr = er != 0;
                if (m_wr) begin
                    m_data = {IW'(g), pl};
`ifdef SCFIFO_S_WR_ARB_PKT_LOCK_EN
                    m_lock = ((req_last >> g) & 1) == 0;
                    m_lid  = g;
                    if (!m_lock) m_ptr = g;
`else
                    m_ptr = g;
`endif
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        req_valid = '1; req_last = '1;
        #2;
        chk_zero("reset");
        @(posedge clock); #1;
        step();
        req_valid = '0;
        aclr_n = 1;
        #1;
        chk("ready_after_release", req_ready, 0);
        step();

        // all four valid for 8 cycles
        clr_log();
        req_last = '1;
        for (int i = 0; i < 8; i++) begin
            req_valid = '1;
            req_data  = (N*W)'({$urandom(), $urandom(), $urandom()});
            step();
        end
        req_valid = '0;
        step();
        chk_ids("rr_ids", 8, '{0, 1, 2, 3, 0, 1, 2, 3});
        chk("first_wr_cycle", got_cyc.size() > 0 ? got_cyc[0] : -1, 1);
        chk("last_wr_cycle", got_cyc.size() > 7 ? got_cyc[7] : -1, 8);

        // single beat from requester 2
        clr_log();
        req_valid = 4'b0100;
        req_data  = '0;
        req_data[2*W +: W] = 20'h12345;
        step();
        req_valid = '0;
        step(); step();
        chk("single_count", got_data.size(), 1);
        chk("single_data", got_data.size() > 0 ? got_data[0] : '0, 22'h212345);

        // almost_full blocks all grants
        clr_log();
        fifo_almost_full = 1; req_valid = '1;
        for (int i = 0; i < 5; i++) step();
        fifo_almost_full = 0; req_valid = '0;
        step(); step();
        chk("af_writes", got_id.size(), 0);

        // overflow sticky until sclr, sclr resets ptr
        req_valid = 4'b0001;
        step();
        req_valid = '0; fifo_full = 1;
        step();
        fifo_full = 0;
        chk("ovf_set", overflow_err, 1);
        step(); step(); step();
        chk("ovf_sticky", overflow_err, 1);
        sclr = 1;
        step();
        sclr = 0;
        chk("fifo_sclr_next", fifo_sclr, 1);
        chk("ovf_cleared", overflow_err, 0);
        clr_log();
        req_valid = '1;
        step();
        req_valid = '0;
        step();
        chk("after_sclr_id", got_id.size() > 0 ? got_id[0] : -1, 0);

        // req 1 sends three beats while req 0 and 3 wait
        clr_log();
        req_valid = 4'b1011; req_last = 4'b1001;
        step(); step();
        req_last = 4'b1011;
        step();
        req_valid = 4'b1001;
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step(); step();
`ifdef SCFIFO_S_WR_ARB_PKT_LOCK_EN
        chk_ids("lock_ids", 5, '{1, 1, 1, 3, 0, 0, 0, 0});
`else
        chk_ids("nolock_ids", 5, '{1, 3, 0, 3, 0, 0, 0, 0});
`endif

        // async reset in the middle of a packet
        req_valid = 4'b0010; req_last = '0;
        step();
        req_valid = '1;
        #2 aclr_n = 0;
        #1;
        chk_zero("async");
        model_reset();
        @(posedge clock); #1;
        step();
        aclr_n = 1;
        step();
        clr_log();
        req_last = '1;
        step();
        req_valid = '0;
        step();
        chk("post_reset_id", got_id.size() > 0 ? got_id[0] : -1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid        = N'($urandom());
            req_last         = N'($urandom());
            req_data         = (N*W)'({$urandom(), $urandom(), $urandom()});
            fifo_almost_full = ($urandom_range(99) < 15);
            fifo_full        = ($urandom_range(99) < 5);
            sclr             = ($urandom_range(99) < 2);
            step();
        end
        req_valid = '0; fifo_almost_full = 0; fifo_full = 0; sclr = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scfifo_s_wr_arb.md
SCFIFO_S_WR_ARB -- requirements
Module: scfifo_s_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter WIDTH, default 20, requester payload width.
REQ-003 SHALL have parameter ID_W, default 2, requester-id width; SHALL equal clog2(NUM_REQ).
REQ-004 SHALL have port clock  in  1  single clock for all logic.
REQ-005 SHALL have port aclr_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port sclr  in  1  synchronous clear, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester beat valid.
REQ-008 SHALL have port req_last  in  NUM_REQ  per-requester last beat of packet.
REQ-009 SHALL have port req_data  in  NUM_REQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_ready  out  NUM_REQ  per-requester accept.
REQ-011 SHALL have port fifo_data  out  ID_W+WIDTH  {id, payload} to shared FIFO data input.
REQ-012 SHALL have port fifo_wrreq  out  1  FIFO write request.
REQ-013 SHALL have port fifo_full  in  1  FIFO full flag.
REQ-014 SHALL have port fifo_almost_full  in  1  FIFO almost_full flag.
REQ-015 SHALL have port fifo_sclr  out  1  synchronous clear forwarded to FIFO.
REQ-016 SHALL have port overflow_err  out  1  sticky error flag.

Function
REQ-017 Handshake: beat from requester i SHALL be accepted in a cycle where req_valid[i] & req_ready[i].
REQ-018 req_ready SHALL be one-hot or zero; all bits SHALL be 0 while fifo_almost_full=1 or sclr=1.
REQ-019 Round-robin: grant SHALL go to the first valid requester searching from (ptr+1) mod NUM_REQ upward, wrapping.
REQ-020 ptr SHALL update to the accepted requester index on every accepted beat subject to REQ-030; otherwise it holds.
REQ-021 Latency: beat accepted in cycle t SHALL produce fifo_wrreq=1 and fifo_data={i, payload} in cycle t+1 (registered outputs).
REQ-022 fifo_wrreq SHALL be 0 in any cycle not following an acceptance; fifo_data SHALL hold its last value then.
REQ-023 Requirement on integration: FIFO ALMOST_FULL_VALUE SHALL be <= NUM_WORDS-2, so one in-flight beat never overflows.
REQ-024 overflow_err SHALL set when fifo_wrreq=1 and fifo_full=1 in the same cycle, and clear only on reset or sclr.
REQ-025 State machine: IDLE (no lock), LOCKED (grant held for requester lock_id).
REQ-026 IDLE -> LOCKED on accepted beat with req_last=0 (only when REQ-030 macro defined); LOCKED -> IDLE on accepted beat from lock_id with req_last=1.
REQ-027 In LOCKED, only lock_id SHALL be eligible for grant; other valids SHALL wait regardless of priority.
REQ-028 Simultaneous valids with no lock: exactly one grant per cycle; max one beat accepted per cycle.
REQ-029 fifo_sclr SHALL equal sclr registered one cycle; sclr SHALL clear ptr, state, outputs as reset does.

Configuration
REQ-030 Macro SCFIFO_S_WR_ARB_PKT_LOCK_EN: defined -> packet lock per REQ-025..027, ptr updates only on the beat that returns to IDLE; undefined -> no LOCKED state, req_last ignored, grant re-arbitrates every beat.

Reset
REQ-031 On aclr_n=0 (asynchronous): req_ready=0, fifo_wrreq=0, fifo_data=0, fifo_sclr=0, overflow_err=0, state=IDLE, ptr=NUM_REQ-1 (requester 0 highest priority first).
REQ-032 Reset mid-packet SHALL abandon the lock; no partial-packet recovery is performed.
REQ-033 Outputs SHALL leave reset values only on the first clock edge after aclr_n rises.

Verification
REQ-034 All 4 valid, last=1, almost_full=0 for 8 cycles -> accepted ids 0,1,2,3,0,1,2,3; fifo_wrreq high cycles 2..9.
REQ-035 Req 2 single beat payload 0x12345 at cycle 5 -> fifo_data=0x2_12345, fifo_wrreq=1 at cycle 6 only.
REQ-036 almost_full=1 cycles 10..14 with all valid -> req_ready=0 cycles 10..14, fifo_wrreq=0 cycles 11..15.
REQ-037 PKT_LOCK_EN: req 1 sends 3-beat packet (last on beat 3), req 0 and 3 valid -> ids 1,1,1 then 3 then 0.
REQ-038 Force fifo_full=1 with fifo_wrreq=1 -> overflow_err=1 next cycle, stays 1 until sclr; sclr at cycle 20 -> fifo_sclr=1 at 21, ptr reset.
REQ-039 aclr_n low mid-LOCKED packet -> all outputs zero immediately; after release req 0 granted first.
